// File: rtl/regfile_read_stage.sv
// regfile_read_stage
//   Operand-fetch stage feeding the ALU. Holds a 2^ADDR_W x WIDTH register
//   file (one write port, two read ports). Accepted read requests return
//   operands A/B and the ALU select s one cycle later. Same-cycle writes are
//   bypassed into reads, and writes refresh operands held during a stall.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   rd_valid   read request present
//   rd_addr_a  source register for operand A
//   rd_addr_b  source register for operand B
//   op_in      ALU select travelling with the request
//   wr_en      write strobe from write-back
//   wr_addr    destination register
//   wr_data    write data
//   stall      downstream not ready, hold outputs
//   A, B       registered operands
//   s          registered ALU select
//   out_valid  A/B/s hold a valid operand set
//
// State   | meaning
// --------+--------------------------------------------
// EMPTY   | no valid operand set on the outputs
// VALID   | A/B/s hold an accepted operand set

module regfile_read_stage #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_valid,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    input  logic [2:0]        op_in,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              stall,
    output logic [WIDTH-1:0]  A,
    output logic [WIDTH-1:0]  B,
    output logic [2:0]        s,
    output logic              out_valid
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        EMPTY = 1'b0,
        VALID = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2:0]         s_q, s_d;
    logic [ADDR_W-1:0]  held_a_q, held_a_d;
    logic [ADDR_W-1:0]  held_b_q, held_b_d;

    logic               wr_live;
    logic               accept;
    logic [WIDTH-1:0]   val_a;
    logic [WIDTH-1:0]   val_b;

    // A write to r0 is never live, so r0 stays at its reset value of zero.
    assign wr_live = wr_en && (wr_addr != '0);
    assign accept  = rd_valid && !stall;

    // Bypass: a write landing this edge is what the read returns.
    assign val_a = (wr_live && (wr_addr == rd_addr_a)) ? wr_data : mem_q[rd_addr_a];
    assign val_b = (wr_live && (wr_addr == rd_addr_b)) ? wr_data : mem_q[rd_addr_b];

    always_comb begin
        mem_d = mem_q;
        if (wr_live) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        s_d      = s_q;
        held_a_d = held_a_q;
        held_b_d = held_b_q;

        if (accept) begin
            state_d  = VALID;
            a_d      = val_a;
            b_d      = val_b;
            s_d      = op_in;
            held_a_d = rd_addr_a;
            held_b_d = rd_addr_b;
        end else if (!stall) begin
            state_d = EMPTY;
        end else if (state_q == VALID && wr_live) begin
            // Held operands track writes to their source registers while stalled.
            if (wr_addr == held_a_q) begin
                a_d = wr_data;
            end
            if (wr_addr == held_b_q) begin
                b_d = wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            held_a_q <= '0;
            held_b_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            s_q      <= s_d;
            held_a_q <= held_a_d;
            held_b_q <= held_b_d;
            mem_q    <= mem_d;
        end
    end

    assign A         = a_q;
    assign B         = b_q;
    assign s         = s_q;
    assign out_valid = (state_q == VALID);

endmodule

// File: tb/tb_regfile_read_stage.sv
module tb_regfile_read_stage;

    logic        clk;
    logic        rst_n;
    logic        rd_valid;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic [2:0]  op_in;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        stall;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  s;
    logic        out_valid;

    regfile_read_stage #(.WIDTH(32), .ADDR_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_valid  (rd_valid),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .op_in     (op_in),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .stall     (stall),
        .A         (A),
        .B         (B),
        .s         (s),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of the stage
    logic [31:0] mreg [32];
    logic [31:0] exp_a, exp_b;
    logic [2:0]  exp_s;
    logic        exp_v;
    logic [4:0]  held_a, held_b;
    logic [66:0] sb [$];
    logic [66:0] ent;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mreg[i] = '0;
        exp_a = '0; exp_b = '0; exp_s = '0; exp_v = 1'b0;
        held_a = '0; held_b = '0;
        sb.delete();
    endtask

    // Drive one cycle of stimulus, clock it, advance the model, push accepted
    // operand sets to the scoreboard; returns #1 after the edge.
    task automatic step(input logic rv, input logic [4:0] ra, input logic [4:0] rb,
                        input logic [2:0] op, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic st);
        logic [31:0] va, vb;
        rd_valid = rv; rd_addr_a = ra; rd_addr_b = rb; op_in = op;
        wr_en = we; wr_addr = wa; wr_data = wd; stall = st;
        va = (we && wa == ra && ra != 0) ? wd : mreg[ra];
        vb = (we && wa == rb && rb != 0) ? wd : mreg[rb];
        @(posedge clk);
        if (!st && rv) begin
            exp_a = va; exp_b = vb; exp_s = op; exp_v = 1'b1;
            held_a = ra; held_b = rb;
            sb.push_back({va, vb, op});
        end else if (!st) begin
            exp_v = 1'b0;
        end else if (exp_v && we && wa != 0) begin
            if (wa == held_a) exp_a = wd;
            if (wa == held_b) exp_b = wd;
        end
        if (we && wa != 0) mreg[wa] = wd;
        #1;
        rd_valid = 1'b0; wr_en = 1'b0; stall = 1'b0;
    endtask

    task automatic test_reset();
        step(1, 5'd1, 5'd2, 3'd3, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (A !== 32'h0 || B !== 32'h0 || s !== 3'b000 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: A=%h B=%h s=%b v=%b required 0 0 000 0", A, B, s, out_valid);
        end
        model_reset();
        #2 rst_n = 1'b1;
        step(1, 5'd5, 5'd9, 3'd0, 0, 0, 0, 0);
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL reset_read: scoreboard empty, required one entry");
        end else begin
            ent = sb.pop_front();
            if (A !== 32'h0 || B !== 32'h0 || A !== ent[66:35] || B !== ent[34:3] || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_read: A=%h B=%h v=%b required 0 0 1", A, B, out_valid);
            end
        end
    endtask

    task automatic test_basic_fetch();
        step(0, 0, 0, 0, 1, 5'd3, 32'h0000_0007, 0);
        step(0, 0, 0, 0, 1, 5'd4, 32'hFFFF_FFFE, 0);
        step(1, 5'd3, 5'd4, 3'b001, 0, 0, 0, 0);
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL basic_fetch: scoreboard empty");
        end else begin
            ent = sb.pop_front();
            if (A !== ent[66:35] || B !== ent[34:3] || s !== ent[2:0] || out_valid !== 1'b1
                || A !== 32'h7 || B !== 32'hFFFF_FFFE) begin
                n_fail++;
                $display("FAIL basic_fetch: A=%h B=%h s=%b v=%b required %h %h %b 1",
                         A, B, s, out_valid, ent[66:35], ent[34:3], ent[2:0]);
            end
        end
        step(0, 0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (out_valid !== 1'b0 || A !== 32'h7 || s !== 3'b001) begin
            n_fail++;
            $display("FAIL basic_idle: v=%b A=%h s=%b required 0 00000007 001", out_valid, A, s);
        end
    endtask

    task automatic test_reg0();
        step(0, 0, 0, 0, 1, 5'd0, 32'hDEAD_BEEF, 0);
        step(1, 5'd0, 5'd0, 3'd4, 0, 0, 0, 0);
        step(1, 5'd0, 5'd0, 3'd5, 1, 5'd0, 32'hCAFE_F00D, 0);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL reg0_read%0d: scoreboard empty", k);
            end else begin
                ent = sb.pop_front();
                if (k == 1 && (A !== ent[66:35] || B !== ent[34:3] || s !== ent[2:0] || A !== 32'h0 || B !== 32'h0)) begin
                    n_fail++;
                    $display("FAIL reg0_read%0d: A=%h B=%h s=%b required 0 0 %b", k, A, B, s, ent[2:0]);
                end else if (k == 0 && (ent[66:35] !== 32'h0 || ent[34:3] !== 32'h0)) begin
                    n_fail++;
                    $display("FAIL reg0_read%0d: model A=%h B=%h required 0 0", k, ent[66:35], ent[34:3]);
                end
            end
        end
    endtask

    task automatic test_bypass();
        step(1, 5'd7, 5'd7, 3'd6, 1, 5'd7, 32'h1234_5678, 0);
        n_checks++;
        ent = (sb.size() != 0) ? sb.pop_front() : '1;
        if (A !== ent[66:35] || B !== ent[34:3] || A !== 32'h1234_5678 || B !== 32'h1234_5678 || s !== 3'd6) begin
            n_fail++;
            $display("FAIL bypass_first: A=%h B=%h s=%b required 12345678 12345678 110", A, B, s);
        end
        step(0, 0, 0, 0, 1, 5'd7, 32'h0000_0001, 0);
        step(1, 5'd7, 5'd3, 3'd7, 1, 5'd7, 32'hA5A5_0F0F, 0);
        n_checks++;
        ent = (sb.size() != 0) ? sb.pop_front() : '1;
        if (A !== ent[66:35] || B !== ent[34:3] || A !== 32'hA5A5_0F0F || B !== 32'h7 || s !== 3'd7) begin
            n_fail++;
            $display("FAIL bypass_new: A=%h B=%h s=%b required a5a50f0f 00000007 111", A, B, s);
        end
    endtask

    task automatic test_stall();
        step(0, 0, 0, 0, 1, 5'd2, 32'h10, 0);
        step(0, 0, 0, 0, 1, 5'd6, 32'h20, 0);
        step(1, 5'd2, 5'd6, 3'b010, 0, 0, 0, 0);
        n_checks++;
        ent = (sb.size() != 0) ? sb.pop_front() : '1;
        if (A !== ent[66:35] || B !== ent[34:3] || s !== ent[2:0] || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_accept: A=%h B=%h s=%b v=%b required 10 20 010 1", A, B, s, out_valid);
        end
        step(1, 5'd7, 5'd7, 3'd5, 0, 0, 0, 1);
        n_checks++;
        if (A !== 32'h10 || B !== 32'h20 || s !== 3'b010 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_hold: A=%h B=%h s=%b v=%b required 10 20 010 1", A, B, s, out_valid);
        end
        step(1, 5'd7, 5'd7, 3'd5, 1, 5'd6, 32'h99, 1);
        n_checks++;
        if (A !== exp_a || B !== exp_b || B !== 32'h99 || A !== 32'h10 || s !== 3'b010 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_refresh: A=%h B=%h s=%b v=%b required 10 99 010 1", A, B, s, out_valid);
        end
        step(1, 5'd7, 5'd7, 3'd5, 1, 5'd9, 32'h55, 1);
        n_checks++;
        if (A !== 32'h10 || B !== 32'h99 || s !== 3'b010 || out_valid !== 1'b1 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL stall_nomatch: A=%h B=%h s=%b v=%b sb=%0d required 10 99 010 1 0",
                     A, B, s, out_valid, sb.size());
        end
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 5'd2, 5'd2, 3'd1, 0, 0, 0, 1);
        n_checks++;
        if (out_valid !== 1'b0 || exp_v !== 1'b0 || A !== 32'h10) begin
            n_fail++;
            $display("FAIL stall_empty: v=%b A=%h required 0 10", out_valid, A);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            step(0, 0, 0, 0, 1, 5'(10 + i), 32'h100 * (i + 1) + 32'(i), 0);
        for (int i = 0; i < 2; i++) begin
            step(1, 5'(10 + i), 5'(13 - i), 3'(i), 0, 0, 0, 0);
            n_checks++;
            ent = (sb.size() != 0) ? sb.pop_front() : '1;
            if (A !== ent[66:35] || B !== ent[34:3] || s !== ent[2:0] || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_%0d: A=%h B=%h s=%b v=%b required %h %h %b 1",
                         i, A, B, s, out_valid, ent[66:35], ent[34:3], ent[2:0]);
            end
        end
        rd_valid = 1'b1; rd_addr_a = 5'd12; rd_addr_b = 5'd13; op_in = 3'd2;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (A !== 32'h0 || B !== 32'h0 || s !== 3'b000 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midstream: A=%h B=%h s=%b v=%b required 0 0 000 0", A, B, s, out_valid);
        end
        model_reset();
        rd_valid = 1'b0;
        #2 rst_n = 1'b1;
        step(1, 5'd10, 5'd11, 3'd3, 0, 0, 0, 0);
        step(1, 5'd12, 5'd13, 3'd4, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            ent = (sb.size() != 0) ? sb.pop_front() : '1;
            if (ent[66:3] !== 64'h0 || (k == 1 && (A !== 32'h0 || B !== 32'h0 || s !== 3'd4 || out_valid !== 1'b1))) begin
                n_fail++;
                $display("FAIL reset_cleared%0d: A=%h B=%h s=%b v=%b required 0 0 100 1", k, A, B, s, out_valid);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rd_valid = 1'b0; rd_addr_a = '0; rd_addr_b = '0; op_in = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; stall = 1'b0;
        model_reset();
        #12 rst_n = 1'b1;
        test_reset();
        test_basic_fetch();
        test_reg0();
        test_bypass();
        test_stall();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_read_stage.md
# regfile_read_stage

Operand-fetch stage placed directly upstream of the 32-bit ALU. It holds a 2^ADDR_W × WIDTH register file with one write port and two read ports. Each accepted read request returns operands A and B together with the 3-bit ALU select `s`, registered one cycle later, so the outputs connect straight to the ALU's A/B/s inputs. Writes from the write-back path are bypassed into same-cycle reads, and they refresh operands that are held during a stall.

## Interface
- WIDTH, 32, data width of every register and of A/B.
- ADDR_W, 5, register address width; the file holds 2^ADDR_W entries.
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- rd_valid  input  1  read request present this cycle.
- rd_addr_a  input  ADDR_W  source register for operand A.
- rd_addr_b  input  ADDR_W  source register for operand B.
- op_in  input  3  ALU select accompanying the request (000 add … 111 xor).
- wr_en  input  1  write strobe from write-back.
- wr_addr  input  ADDR_W  destination register.
- wr_data  input  WIDTH  write data.
- stall  input  1  downstream not ready; hold the current outputs.
- A  output  WIDTH  registered operand A.
- B  output  WIDTH  registered operand B.
- s  output  3  registered ALU select.
- out_valid  output  1  A/B/s hold a valid operand set.

## Operation
- Register 0 always reads as 0. Writes to address 0 are discarded.
- **Write:** when wr_en=1 and wr_addr≠0, the entry is updated at the rising edge. A write is accepted regardless of stall or rd_valid.
- **Accept:** a request is accepted at an edge where rd_valid=1 and stall=0. On acceptance:
  - A ← value(rd_addr_a), B ← value(rd_addr_b), s ← op_in, out_valid ← 1.
  - The stage also latches rd_addr_a and rd_addr_b internally as held addresses.
- **Idle:** at an edge with stall=0 and rd_valid=0, out_valid ← 0. A, B and s keep their last values.
- **Bypass:** value(x) is wr_data when wr_en=1, wr_addr=x and x≠0. Otherwise it is the stored entry. The read therefore sees the write landing in the same cycle.
- **Stall:** at an edge with stall=1, out_valid, s and the held addresses are frozen, and rd_valid is ignored (no acceptance). Held-operand refresh still applies:
  - if out_valid=1, wr_en=1, wr_addr≠0 and wr_addr equals the held A address, then A ← wr_data;
  - the same rule applies independently to B;
  - both update if both held addresses match.
- A and B obey two's-complement-agnostic raw bit semantics; the stage performs no arithmetic.
- State is two flags: EMPTY (out_valid=0) and VALID (out_valid=1).
  - EMPTY→VALID on accept.
  - VALID→VALID on accept or stall.
  - VALID→EMPTY at an edge with stall=0 and rd_valid=0.
  - EMPTY stays EMPTY while stall=1.

## Timing
- Read latency is 1 cycle: a request accepted at edge N is visible on the outputs after edge N.
- Back-to-back accepts deliver one operand set per cycle. There are no bubbles when stall=0.
- Write-to-read: a write at edge N is visible to a read accepted at edge N (bypass) or at any later edge.
- **Reset:** asserting rst_n=0 immediately, without waiting for clk, forces:
  - every register entry to 0;
  - A=0, B=0, s=3'b000, out_valid=0;
  - held addresses to 0.
  This applies mid-stall or mid-stream. Any in-flight request is lost.
- **Reset release:** the first edge after rst_n rises may accept a request.
- **Simultaneous events:** a write and a read of the same register on one edge returns the new data. A write during stall with a non-matching address leaves A/B unchanged.

## Test plan
- **Reset:** drive rst_n=0 between edges → A=B=0, s=000, out_valid=0 immediately. After release, reading r5, r9 returns 0, 0.
- **Basic fetch:** write r3=0x0000_0007 and r4=0xFFFF_FFFE on separate edges, then request a=3, b=4, op_in=001. One cycle later: A=0x7, B=0xFFFF_FFFE, s=001, out_valid=1. Next edge with rd_valid=0 → out_valid=0.
- **Register 0:** write r0=0xDEAD_BEEF, then read a=0, b=0 → A=B=0. A same-cycle write to r0 during the read also returns 0.
- **Bypass:** on one edge, wr_en with r7=0x1234_5678 and read a=7, b=7 → A=B=0x1234_5678. Repeat with r7 previously 0x1 to confirm the new value is returned.
- **Stall with refresh:**
  - accept a=2 (0x10), b=6 (0x20), op 010;
  - hold stall=1 for 3 cycles and, during the stall, write r6=0x99;
  - required: B becomes 0x99 after that edge, A stays 0x10, s stays 010, out_valid stays 1;
  - rd_valid=1 requests during the stall are not accepted.
- **Reset mid-stream:** stream 4 back-to-back requests, then assert rst_n after the second → outputs clear at once, out_valid=0, all registers read 0 afterwards.
